// File: rtl/image_pkg.sv
// Shared definitions for the grayscale image ROM and its raster-scan reader.
// Holds the pixel width, default frame size, address-width helper and reader FSM states.
package image_pkg;

    localparam int PIXEL_W        = 8;
    localparam int IMG_WIDTH_DEF  = 160;
    localparam int IMG_HEIGHT_DEF = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int addr_w(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel buffer that absorbs the ROM read latency so the stream can stall
// without losing a read that is already in flight.
module pixel_skid_fifo
    import image_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [PIXEL_W-1:0] din,
    input  logic               pop,
    output logic [PIXEL_W-1:0] dout,
    output logic [1:0]         count
);

    logic [PIXEL_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/image_rom_reader.sv
// Raster-scan read initiator: walks the image ROM once per start and streams the
// pixels out with start-of-frame, end-of-line and end-of-frame markers.
module image_rom_reader
    import image_pkg::*;
#(
    parameter  int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter  int IMG_HEIGHT = IMG_HEIGHT_DEF,
    localparam int ADDR_W     = addr_w(IMG_WIDTH, IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIXEL_W-1:0] rom_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PIXEL_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output state_t             fsm_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_Y    = ADDR_W'(IMG_HEIGHT - 1);

    state_t            state, state_nxt;
    logic              all_issued;
    logic              inflight;
    logic [ADDR_W-1:0] x, y;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              accept, issue, pop;

    // m_valid/m_ready: a pixel transfers on each rising edge where both are high;
    // once m_valid rises it stays high with m_data and markers frozen until that transfer.
    assign pop = m_valid & m_ready;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        // Occupancy the FIFO will have after this cycle, counting the read in flight.
        occ       = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = !all_issued && (occ < 3'd2);
                if (pop && m_eof) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            all_issued <= 1'b0;
            inflight   <= 1'b0;
            x          <= '0;
            y          <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (accept) begin
                rom_addr   <= '0;
                all_issued <= 1'b0;
                x          <= '0;
                y          <= '0;
            end else begin
                // rom_addr parks on the last address instead of running past the image.
                if (issue) begin
                    if (rom_addr == LAST_ADDR) all_issued <= 1'b1;
                    else                       rom_addr   <= rom_addr + ADDR_W'(1);
                end
                if (pop) begin
                    if (x == LAST_X) begin
                        x <= '0;
                        y <= (y == LAST_Y) ? '0 : y + ADDR_W'(1);
                    end else begin
                        x <= x + ADDR_W'(1);
                    end
                end
            end
        end
    end

    pixel_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (rom_data),
        .pop   (pop),
        .dout  (m_data),
        .count (fifo_count)
    );

    assign m_valid   = (fifo_count != 2'd0);
    assign m_sof     = m_valid && (x == '0) && (y == '0);
    assign m_eol     = m_valid && (x == LAST_X);
    assign m_eof     = m_valid && (x == LAST_X) && (y == LAST_Y);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_image_rom_reader.sv
// Bench for image_rom_reader: a full 160x120 instance and a tiny 4x2 instance, each fed
// by a synchronous ROM model, checked against a per-frame expected pixel queue.
module tb_image_rom_reader;
    import image_pkg::*;

    localparam int BW = 160, BH = 120, BN = BW * BH;
    localparam int TW = 4,   TH = 2,   TN = TW * TH;

    logic clk = 1'b0;
    logic rst;
    logic sel;          // 0: full-size instance, 1: tiny instance
    logic start_c, ready_c;

    logic        b_busy, b_done, b_valid, b_sof, b_eol, b_eof;
    logic [14:0] b_rom_addr;
    logic [7:0]  b_rom_data, b_data;
    state_t      b_state;

    logic        t_busy, t_done, t_valid, t_sof, t_eol, t_eof;
    logic [2:0]  t_rom_addr;
    logic [7:0]  t_rom_data, t_data;
    state_t      t_state;

    logic [7:0]  t_rom [TN];
    logic [10:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    image_rom_reader u_big (
        .clk(clk), .rst(rst), .start(!sel && start_c), .busy(b_busy), .done(b_done),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .m_valid(b_valid),
        .m_ready(!sel && ready_c), .m_data(b_data), .m_sof(b_sof), .m_eol(b_eol),
        .m_eof(b_eof), .fsm_state(b_state)
    );

    image_rom_reader #(.IMG_WIDTH(TW), .IMG_HEIGHT(TH)) u_tiny (
        .clk(clk), .rst(rst), .start(sel && start_c), .busy(t_busy), .done(t_done),
        .rom_addr(t_rom_addr), .rom_data(t_rom_data), .m_valid(t_valid),
        .m_ready(sel && ready_c), .m_data(t_data), .m_sof(t_sof), .m_eol(t_eol),
        .m_eof(t_eof), .fsm_state(t_state)
    );

    // Synchronous ROMs sharing the clock: full image holds addr[7:0], tiny image random.
    always @(posedge clk) b_rom_data <= b_rom_addr[7:0];
    always @(posedge clk) t_rom_data <= t_rom[t_rom_addr];

    wire         o_valid = sel ? t_valid : b_valid;
    wire         o_busy  = sel ? t_busy  : b_busy;
    wire         o_done  = sel ? t_done  : b_done;
    wire [14:0]  o_addr  = sel ? 15'(t_rom_addr) : b_rom_addr;
    wire [10:0]  o_pix   = sel ? {t_data, t_sof, t_eol, t_eof} : {b_data, b_sof, b_eol, b_eof};
    state_t      o_state;
    assign o_state = sel ? t_state : b_state;

    // Reference frame: pixel a sits at x = a % W, y = a / W in raster order.
    task automatic build_expected();
        int w, n;
        logic [7:0] d;
        w = sel ? TW : BW;
        n = sel ? TN : BN;
        exp_q.delete();
        for (int a = 0; a < n; a++) begin
            d = sel ? t_rom[a] : 8'(a % 256);
            exp_q.push_back({d, a == 0, (a % w) == w - 1, a == n - 1});
        end
    endtask

    // Entered and left at 1ns after a rising edge. Starts a frame in the current cycle
    // (cycle 0), consumes it with the given ready probability, and checks every pixel.
    task automatic stream_frame(input int ready_pct, input bit poke_start);
        int n, cyc, hs, first_valid, done_cyc, last_hs_cyc;
        n = sel ? TN : BN;
        build_expected();
        cyc = 0; hs = 0; first_valid = -1; done_cyc = -1; last_hs_cyc = -1;
        start_c = 1'b1;
        ready_c = 1'b0;
        while (done_cyc < 0 && cyc < 4 * n + 50) begin
            @(posedge clk); #1;
            cyc++;
            start_c = (poke_start && cyc == 5);
            vectors++;
            if (o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy cyc %0d: got %b expected 1", cyc, o_busy);
            end
            if (cyc == 1) begin
                vectors++;
                if (o_addr !== 15'd0) begin
                    miscompares++;
                    $display("FAIL addr_restart: got %0d expected 0", o_addr);
                end
            end
            if (o_done) begin
                done_cyc = cyc;
                start_c  = poke_start;
            end else if (o_valid) begin
                if (first_valid < 0) first_valid = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_pixel cyc %0d: got %h expected none", cyc, o_pix);
                end else if (o_pix !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL pixel[%0d]: got %h expected %h", hs, o_pix, exp_q[0]);
                end
                ready_c = ($urandom_range(99) < ready_pct);
                if (ready_c) begin
                    hs++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else begin
                ready_c = ($urandom_range(99) < ready_pct);
            end
        end
        vectors++;
        if (done_cyc < 0) begin
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end
        vectors++;
        if (hs != n || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pixel_count: got %0d expected %0d", hs, n);
        end
        vectors++;
        if (first_valid != 3) begin
            miscompares++;
            $display("FAIL first_valid_cycle: got %0d expected 3", first_valid);
        end
        vectors++;
        if (done_cyc != last_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL done_after_last: got %0d expected %0d", done_cyc, last_hs_cyc + 1);
        end
        if (ready_pct >= 100) begin
            vectors++;
            if (done_cyc != 3 + n) begin
                miscompares++;
                $display("FAIL full_rate_done: got %0d expected %0d", done_cyc, 3 + n);
            end
        end
        @(posedge clk); #1;
        start_c = 1'b0;
        ready_c = 1'b0;
        vectors++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_state !== IDLE) begin
            miscompares++;
            $display("FAIL after_done: got done=%b busy=%b state=%0d expected 0 0 IDLE",
                     o_done, o_busy, o_state);
        end
        vectors++;
        if (o_addr !== 15'(n - 1)) begin
            miscompares++;
            $display("FAIL addr_hold: got %0d expected %0d", o_addr, n - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_c = 1'b0; ready_c = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++;
            if ({o_busy, o_done, o_valid, o_pix, o_addr} !== '0 || o_state !== IDLE) begin
                miscompares++;
                $display("FAIL reset_values[%0d]: got busy=%b done=%b valid=%b pix=%h addr=%0d state=%0d expected all 0",
                         s, o_busy, o_done, o_valid, o_pix, o_addr, o_state);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_rate();
        sel = 1'b0;
        stream_frame(100, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        stream_frame(50, 1'b0);
    endtask

    task automatic test_tiny_image();
        sel = 1'b1;
        for (int i = 0; i < TN; i++) t_rom[i] = 8'($urandom_range(255));
        #1;
        stream_frame(60, 1'b0);
    endtask

    // start pulsed in RUN and in DONE is ignored; the frame after done starts at once.
    task automatic test_back_to_back();
        sel = 1'b1;
        stream_frame(70, 1'b1);
        for (int i = 0; i < TN; i++) t_rom[i] = 8'($urandom_range(255));
        stream_frame(100, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b1;
        start_c = 1'b1;
        ready_c = 1'b0;
        @(posedge clk); #1;
        start_c = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b1 || o_addr !== 15'd2) begin
            miscompares++;
            $display("FAIL stall_depth: got valid=%b addr=%0d expected 1 2", o_valid, o_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({o_busy, o_done, o_valid, o_pix, o_addr} !== '0 || o_state !== IDLE) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b valid=%b pix=%h addr=%0d state=%0d expected all 0",
                     o_busy, o_valid, o_pix, o_addr, o_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        stream_frame(50, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_tiny_image();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
